// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Handles load-use and branch/jump hazards, memory waits and timeout.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_memrd,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch,
    input  logic             id_jump,
    input  logic             mem_rd,
    input  logic             mem_wr,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT = MEM_TIMEOUT[7:0];

    state_t     state;
    state_t     state_nx;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_nx;
    logic       err_nx;
    logic       memacc;
    logic       lu;
    logic       freeze;

    assign memacc = mem_rd | mem_wr;
    assign lu = ex_memrd && (ex_rt != 5'd0) &&
                ((ex_rt == id_rs) || (ex_rt == id_rt));
    assign freeze = (state == ERR) || (memacc && !dmem_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            mem_err  <= err_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        err_nx      = mem_err;
        case (state)
            RUN: begin
                if (memacc && !dmem_ready) begin
                    state_nx    = MEM_WAIT;
                    wait_cnt_nx = 8'd1;
                end
            end
            MEM_WAIT: begin
                // A dropped access is treated as completion.
                if (!memacc || dmem_ready) begin
                    state_nx    = RUN;
                    wait_cnt_nx = 8'd0;
                end else if (wait_cnt == TIMEOUT) begin
                    state_nx = ERR;
                    err_nx   = 1'b1;
                end else begin
                    wait_cnt_nx = wait_cnt + 8'd1;
                end
            end
            ERR: begin
                state_nx = ERR;
            end
            default: begin
                state_nx    = RUN;
                wait_cnt_nx = 8'd0;
            end
        endcase
    end

    always_comb begin
        dmem_req     = memacc && (state != ERR);
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_flush   = 1'b0;
        exmem_en     = 1'b1;
        memwb_bubble = 1'b0;
        if (reset) begin
            dmem_req     = 1'b0;
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            ifid_flush   = 1'b1;
            idex_en      = 1'b0;
            idex_flush   = 1'b1;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (freeze) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (ex_branch) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (lu) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (id_jump) begin
            ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (!pc_en && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic
// checked every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int TO = 15;
    localparam int CW = 6;
    localparam int SMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [4:0]    id_rs = '0;
    logic [4:0]    id_rt = '0;
    logic          ex_memrd = 1'b0;
    logic [4:0]    ex_rt = '0;
    logic          ex_branch = 1'b0;
    logic          id_jump = 1'b0;
    logic          mem_rd = 1'b0;
    logic          mem_wr = 1'b0;
    logic          dmem_ready = 1'b0;
    logic          dmem_req;
    logic          pc_en;
    logic          ifid_en;
    logic          ifid_flush;
    logic          idex_en;
    logic          idex_flush;
    logic          exmem_en;
    logic          memwb_bubble;
    logic          mem_err;
    logic [CW-1:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt),
        .ex_memrd(ex_memrd), .ex_rt(ex_rt),
        .ex_branch(ex_branch), .id_jump(id_jump),
        .mem_rd(mem_rd), .mem_wr(mem_wr),
        .dmem_ready(dmem_ready), .dmem_req(dmem_req),
        .pc_en(pc_en), .ifid_en(ifid_en),
        .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_flush(idex_flush), .exmem_en(exmem_en),
        .memwb_bubble(memwb_bubble), .mem_err(mem_err),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: error flag, consecutive-wait count, stall count.
    bit m_err = 0;
    int m_wait = 0;
    int m_stall = 0;

    always @(negedge clk) begin
        bit acc, frz, luh;
        bit e_req, e_pc, e_ifen, e_iff, e_iden, e_idf, e_exen, e_bub;
        if (reset) begin
            m_err = 0;
            m_wait = 0;
            m_stall = 0;
            e_req = 0; e_pc = 0; e_ifen = 0; e_iff = 1;
            e_iden = 0; e_idf = 1; e_exen = 0; e_bub = 1;
        end else begin
            acc = mem_rd || mem_wr;
            frz = m_err || (acc && !dmem_ready);
            luh = ex_memrd && ex_rt != 0 &&
                  (ex_rt == id_rs || ex_rt == id_rt);
            e_req = acc && !m_err;
            e_pc = 1; e_ifen = 1; e_iff = 0; e_iden = 1;
            e_idf = 0; e_exen = 1; e_bub = 0;
            if (frz) begin
                e_pc = 0; e_ifen = 0; e_iden = 0;
                e_exen = 0; e_bub = 1;
            end else if (ex_branch) begin
                e_iff = 1; e_idf = 1;
            end else if (luh) begin
                e_pc = 0; e_ifen = 0; e_idf = 1;
            end else if (id_jump) begin
                e_iff = 1;
            end
        end
        chk("dmem_req", int'(dmem_req), int'(e_req));
        chk("pc_en", int'(pc_en), int'(e_pc));
        chk("ifid_en", int'(ifid_en), int'(e_ifen));
        chk("ifid_flush", int'(ifid_flush), int'(e_iff));
        chk("idex_en", int'(idex_en), int'(e_iden));
        chk("idex_flush", int'(idex_flush), int'(e_idf));
        chk("exmem_en", int'(exmem_en), int'(e_exen));
        chk("memwb_bubble", int'(memwb_bubble), int'(e_bub));
        chk("mem_err", int'(mem_err), int'(m_err));
        chk("stall_cycles", int'(stall_cycles), m_stall);
        if (!reset) begin
            if (!e_pc && m_stall < SMAX) m_stall++;
            if (!m_err) begin
                if (frz) begin
                    if (m_wait == TO) m_err = 1;
                    else m_wait++;
                end else begin
                    m_wait = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; ex_memrd = 0; ex_rt = 0;
        ex_branch = 0; id_jump = 0;
        mem_rd = 0; mem_wr = 0; dmem_ready = 0;
    endtask

    initial begin
        int hold;
        idle();
        reset = 1;
        tick();
        #5;
        chk("lit_reset_req", int'(dmem_req), 0);
        chk("lit_reset_flush", int'(ifid_flush), 1);
        tick();
        reset = 0;

        // Load-use on rs
        ex_memrd = 1; ex_rt = 5; id_rs = 5;
        #5;
        chk("lit_lu_pc", int'(pc_en), 0);
        chk("lit_lu_idf", int'(idex_flush), 1);
        tick();
        idle();
        #5;
        chk("lit_lu_cnt", int'(stall_cycles), 1);
        chk("lit_lu_after", int'(pc_en), 1);
        tick();

        // No hazard: rt 0 and mismatch
        ex_memrd = 1; ex_rt = 0; id_rs = 0;
        #5;
        chk("lit_rt0", int'(pc_en), 1);
        tick();
        ex_rt = 5; id_rs = 6; id_rt = 4;
        #5;
        chk("lit_nomatch", int'(ifid_en), 1);
        tick();
        idle();

        // Store waiting three cycles
        mem_wr = 1;
        for (int i = 0; i < 3; i++) begin
            #5;
            chk("lit_st_req", int'(dmem_req), 1);
            chk("lit_st_bub", int'(memwb_bubble), 1);
            tick();
        end
        dmem_ready = 1;
        #5;
        chk("lit_st_done_req", int'(dmem_req), 1);
        chk("lit_st_done_pc", int'(pc_en), 1);
        tick();
        idle();
        #5;
        chk("lit_st_run", int'(exmem_en), 1);
        tick();

        // Branch wins over load-use; ignored while waiting
        ex_branch = 1; ex_memrd = 1; ex_rt = 3; id_rt = 3;
        #5;
        chk("lit_br_pc", int'(pc_en), 1);
        chk("lit_br_iff", int'(ifid_flush), 1);
        tick();
        mem_rd = 1;
        #5;
        chk("lit_brw_iff", int'(ifid_flush), 0);
        tick();
        dmem_ready = 1;
        #5;
        chk("lit_brw_done", int'(idex_flush), 1);
        tick();
        idle();

        // Timeout into error
        mem_rd = 1;
        for (int i = 0; i < 16; i++) begin
            #5;
            if (i == 15) chk("lit_to_last_req", int'(dmem_req), 1);
            tick();
        end
        #5;
        chk("lit_to_err", int'(mem_err), 1);
        chk("lit_to_req", int'(dmem_req), 0);
        tick();
        dmem_ready = 1;
        for (int i = 0; i < 70; i++) tick();
        #5;
        chk("lit_err_sticky", int'(mem_err), 1);
        chk("lit_sat", int'(stall_cycles), SMAX);
        tick();

        // Reset in the middle of a wait
        reset = 1;
        tick();
        reset = 0;
        idle();
        mem_rd = 1;
        tick();
        tick();
        reset = 1;
        #1;
        chk("lit_rst_req", int'(dmem_req), 0);
        chk("lit_rst_cnt", int'(stall_cycles), 0);
        tick();
        reset = 0;
        idle();
        #5;
        chk("lit_rst_pc", int'(pc_en), 1);
        chk("lit_rst_err", int'(mem_err), 0);
        tick();

        // Random traffic
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 149) == 0);
            id_rs = 5'($urandom_range(0, 3));
            id_rt = 5'($urandom_range(0, 3));
            ex_rt = 5'($urandom_range(0, 3));
            ex_memrd = $urandom_range(0, 1) == 1;
            ex_branch = $urandom_range(0, 3) == 0;
            id_jump = $urandom_range(0, 3) == 0;
            if (hold > 0) begin
                mem_rd = 1; mem_wr = 0; dmem_ready = 0;
                hold--;
            end else begin
                mem_rd = $urandom_range(0, 9) < 3;
                mem_wr = $urandom_range(0, 9) < 3;
                dmem_ready = $urandom_range(0, 1) == 1;
                if ($urandom_range(0, 39) == 0)
                    hold = $urandom_range(1, 20);
            end
            tick();
        end
        reset = 0;
        idle();
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
